// File: rtl/controller_pkg.sv
// ---------------------------------------------------------------------------
// controller_pkg
//   Shared definitions for the serial controller link: button bit positions,
//   responder state encodings and the default frame width.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package controller_pkg;

  localparam int DEFAULT_NUM_BITS = 8;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
//   Multi-flop synchroniser for an asynchronous level, followed by one more
//   flop so rising/falling edges of the synchronised copy become 1-cycle
//   strobes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the async input through the synchroniser and keep a delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

`default_nettype wire

// File: rtl/controller_responder.sv
// ---------------------------------------------------------------------------
// controller_responder
//   Device-side emulation of a pad's parallel-in/serial-out register. LATCH
//   loads the button vector (transparently while high), each PULSE rising
//   edge shifts one bit out on the active-low DATA line.
//   Optional feature macro: CTRL_TURBO_EN (turbo auto-fire on A and B).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module controller_responder
  import controller_pkg::*;
#(
  parameter int NUM_BITS     = DEFAULT_NUM_BITS,
  parameter int SYNC_STAGES  = 2,
  parameter int TURBO_PERIOD = 4
) (
  input  logic                I_CLK_33MHZ,
  input  logic                I_RESET_N,
  input  logic                I_LATCH,
  input  logic                I_PULSE,
  input  logic [NUM_BITS-1:0] I_BUTTONS,
  input  logic [1:0]          I_TURBO,
  output logic                O_DATA,
  output logic                O_POLL,
  output logic                O_DONE
);

  localparam int CW = $clog2(NUM_BITS + 1);

  logic                latch_rise;
  logic                latch_fall;
  logic                pulse_rise;
  logic                pulse_fall_unused;
  logic [NUM_BITS-1:0] load_val;
  logic [NUM_BITS-1:0] sreg;
  logic [CW-1:0]       count;
  ctrl_state_t         state;

  sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (I_CLK_33MHZ),
    .rst_n (I_RESET_N),
    .d     (I_LATCH),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (I_CLK_33MHZ),
    .rst_n (I_RESET_N),
    .d     (I_PULSE),
    .rise  (pulse_rise),
    .fall  (pulse_fall_unused)
  );

`ifdef CTRL_TURBO_EN
  localparam int TCW = $clog2(TURBO_PERIOD + 1);

  logic [TCW-1:0] latch_cnt;
  logic           phase;

  // Count latch rises; the phase flips as the first latch of each new group
  // of TURBO_PERIOD arrives, so every group sees one constant phase.
  always_ff @(posedge I_CLK_33MHZ or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      latch_cnt <= '0;
      phase     <= 1'b0;
    end else if (latch_rise) begin
      if (latch_cnt == TCW'(TURBO_PERIOD)) begin
        latch_cnt <= TCW'(1);
        phase     <= ~phase;
      end else begin
        latch_cnt <= latch_cnt + 1'b1;
      end
    end
  end

  // Turbo-requested buttons only read pressed during the active phase.
  always_comb begin
    load_val        = I_BUTTONS;
    load_val[BTN_A] = I_BUTTONS[BTN_A] & (~I_TURBO[0] | phase);
    load_val[BTN_B] = I_BUTTONS[BTN_B] & (~I_TURBO[1] | phase);
  end
`else
  logic unused_turbo;

  assign unused_turbo = ^I_TURBO;
  assign load_val     = I_BUTTONS;
`endif

  // Read sequencer: a latch rise restarts the read from any state and wins
  // over a pulse edge seen in the same cycle.
  always_ff @(posedge I_CLK_33MHZ or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state  <= IDLE;
      sreg   <= '0;
      count  <= '0;
      O_DATA <= 1'b1;
      O_POLL <= 1'b0;
      O_DONE <= 1'b0;
    end else begin
      O_POLL <= 1'b0;
      if (latch_rise) begin
        state  <= LOAD;
        sreg   <= load_val;
        count  <= '0;
        O_DONE <= 1'b0;
        O_DATA <= ~load_val[0];
      end else begin
        case (state)
          IDLE: begin
            O_DATA <= 1'b1;
          end
          LOAD: begin
            sreg   <= load_val;
            count  <= '0;
            O_DATA <= ~load_val[0];
            if (latch_fall) begin
              state  <= SHIFT;
              O_POLL <= 1'b1;
            end
          end
          SHIFT: begin
            if (pulse_rise) begin
              sreg <= sreg >> 1;
              if (count == CW'(NUM_BITS - 1)) begin
                count  <= CW'(NUM_BITS);
                state  <= DONE;
                O_DONE <= 1'b1;
                O_DATA <= 1'b0;
              end else begin
                count  <= count + 1'b1;
                O_DATA <= ~sreg[1];
              end
            end
          end
          DONE: begin
            O_DONE <= 1'b1;
            O_DATA <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
